// File: rtl/dpi_flow_ctx.sv
// Per-flow DFA context sequencer: restores a flow's matcher state before each packet,
// streams bytes, saves the final state back. Optional feature macro: DPI_FLOW_CTX_CLR_EN.
module dpi_flow_ctx #(
    parameter int FLOW_W  = 4,
    parameter int STATE_W = 11,
    parameter int OFS_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pkt_vld,
    output logic               pkt_rdy,
    input  logic [7:0]         pkt_data,
    input  logic               pkt_sop,
    input  logic               pkt_eop,
    input  logic [FLOW_W-1:0]  pkt_flow,
    output logic [7:0]         char_out,
    output logic               char_out_vld,
    output logic [STATE_W-1:0] state_load,
    output logic               state_load_vld,
    input  logic [STATE_W-1:0] mtch_state,
    input  logic               mtch_accept,
    output logic               match_vld,
    output logic [FLOW_W-1:0]  match_flow,
    output logic [OFS_W-1:0]   match_offset,
    output logic [15:0]        drop_cnt,
`ifdef DPI_FLOW_CTX_CLR_EN
    input  logic               ctx_clr,
    input  logic [FLOW_W-1:0]  ctx_clr_flow,
`endif
    output logic [1:0]         dbg_state
);

    localparam int CTX_N = 2 ** FLOW_W;

    // Handshake: a beat transfers on a cycle where pkt_vld & pkt_rdy at the rising edge;
    // pkt_rdy may depend combinationally on pkt_vld/pkt_sop, pkt_vld must not depend on pkt_rdy.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_SAVE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FLOW_W-1:0]   cur_flow_q, cur_flow_d;
    logic                first_beat_q, first_beat_d;
    logic [OFS_W-1:0]    offset_q, offset_d;
    logic [STATE_W-1:0]  ctx_q [CTX_N];
    logic [15:0]         drop_cnt_q;
    logic                match_vld_q;
    logic [FLOW_W-1:0]   match_flow_q;
    logic [OFS_W-1:0]    match_offset_q;

    logic                stream_hold;
    logic                save_en;
    logic                drop_inc;
    logic                accept_hit;
    logic [STATE_W-1:0]  load_val;

    // A sop arriving mid-packet means the previous packet lost its eop: close it out first.
    assign stream_hold = pkt_vld & pkt_sop & ~first_beat_q;
    assign drop_inc    = (state_q == S_IDLE) & pkt_vld & ~pkt_sop;
    assign accept_hit  = char_out_vld & mtch_accept;

`ifdef DPI_FLOW_CTX_CLR_EN
    assign load_val = (ctx_clr && (ctx_clr_flow == cur_flow_q)) ? '0 : ctx_q[cur_flow_q];
`else
    assign load_val = ctx_q[cur_flow_q];
`endif

    always_comb begin
        state_d        = state_q;
        cur_flow_d     = cur_flow_q;
        first_beat_d   = first_beat_q;
        offset_d       = offset_q;
        pkt_rdy        = 1'b0;
        char_out       = '0;
        char_out_vld   = 1'b0;
        state_load     = '0;
        state_load_vld = 1'b0;
        save_en        = 1'b0;
        case (state_q)
            S_IDLE: begin
                pkt_rdy = pkt_vld & ~pkt_sop;
                if (pkt_vld && pkt_sop) begin
                    cur_flow_d = pkt_flow;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                state_load     = load_val;
                state_load_vld = 1'b1;
                first_beat_d   = 1'b1;
                offset_d       = '0;
                state_d        = S_STREAM;
            end
            S_STREAM: begin
                pkt_rdy      = ~stream_hold;
                char_out     = pkt_data;
                char_out_vld = pkt_vld & ~stream_hold;
                if (stream_hold) begin
                    state_d = S_SAVE;
                end else if (pkt_vld) begin
                    first_beat_d = 1'b0;
                    if (offset_q != '1) begin
                        offset_d = offset_q + OFS_W'(1);
                    end
                    if (pkt_eop) begin
                        state_d = S_SAVE;
                    end
                end
            end
            S_SAVE: begin
                save_en = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_flow_q   <= '0;
            first_beat_q <= 1'b0;
            offset_q     <= '0;
        end else begin
            state_q      <= state_d;
            cur_flow_q   <= cur_flow_d;
            first_beat_q <= first_beat_d;
            offset_q     <= offset_d;
        end
    end

    // Clear is written after the save so it takes priority on the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CTX_N; i++) begin
                ctx_q[i] <= '0;
            end
        end else begin
            if (save_en) begin
                ctx_q[cur_flow_q] <= mtch_state;
            end
`ifdef DPI_FLOW_CTX_CLR_EN
            if (ctx_clr) begin
                ctx_q[ctx_clr_flow] <= '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_vld_q    <= 1'b0;
            match_flow_q   <= '0;
            match_offset_q <= '0;
        end else begin
            match_vld_q <= accept_hit;
            if (accept_hit) begin
                match_flow_q   <= cur_flow_q;
                match_offset_q <= offset_q;
            end
        end
    end

    assign match_vld    = match_vld_q;
    assign match_flow   = match_flow_q;
    assign match_offset = match_offset_q;
    assign drop_cnt     = drop_cnt_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/dpi_flow_ctx.md
# dpi_flow_ctx

Per-flow context sequencer that sits directly upstream of each regex DFA matcher in the packet-inspection pipeline. Accepts a byte stream tagged with a flow ID, restores that flow's saved DFA state into the matcher before the packet's first byte, streams the bytes, and saves the matcher's final state back to a context table after the last byte. Matches spanning packet boundaries of the same flow are therefore detected. Matcher accept pulses are turned into registered match reports carrying flow ID and byte offset.

## Interface
- FLOW_W, 4: flow ID width; context table holds 2^FLOW_W entries
- STATE_W, 11: DFA state width; equals the matcher's state width
- OFS_W, 16: byte offset counter width
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pkt_vld  in  1  upstream byte valid
- pkt_rdy  out  1  upstream ready; a beat transfers when pkt_vld & pkt_rdy
- pkt_data  in  8  byte
- pkt_sop  in  1  first byte of packet
- pkt_eop  in  1  last byte of packet
- pkt_flow  in  FLOW_W  flow ID; sampled on the sop beat only
- char_out  out  8  to matcher char_in
- char_out_vld  out  1  to matcher char_in_vld
- state_load  out  STATE_W  to matcher state_in
- state_load_vld  out  1  to matcher state_in_vld
- mtch_state  in  STATE_W  from matcher state_out
- mtch_accept  in  1  from matcher accept_out
- match_vld  out  1  one-cycle match report strobe
- match_flow  out  FLOW_W  flow of reported match
- match_offset  out  OFS_W  0-based byte index in packet of the accepting byte
- drop_cnt  out  16  count of discarded orphan beats, saturating

## Operation
- FSM: IDLE, LOAD, STREAM, SAVE. Registered cur_flow, first_beat, offset.
- IDLE: pkt_rdy = pkt_vld & !pkt_sop (orphan non-sop beats consumed and dropped, drop_cnt += 1, saturates at 0xFFFF). pkt_vld & pkt_sop: latch cur_flow = pkt_flow, go LOAD; sop beat not consumed.
- LOAD: pkt_rdy = 0; state_load = ctx[cur_flow], state_load_vld = 1; first_beat = 1, offset = 0; go STREAM.
- STREAM: pkt_rdy = 1 except when pkt_vld & pkt_sop & !first_beat (new packet without eop: beat held, go SAVE). char_out = pkt_data, char_out_vld = pkt_vld & pkt_rdy. Each transfer clears first_beat, increments offset (saturates at all-ones). Transfer with pkt_eop: go SAVE.
- SAVE: pkt_rdy = 0; ctx[cur_flow] <= mtch_state (already includes last byte); go IDLE.
- Match report: on char_out_vld & mtch_accept, next cycle match_vld = 1, match_flow = cur_flow, match_offset = offset of that byte. Otherwise match_vld = 0; match_flow/match_offset hold.
- state_load_vld and char_out_vld are never asserted together.

## Timing
- Reset: state IDLE, all ctx entries 0, pkt_rdy 0, char_out_vld 0, state_load_vld 0, match_vld 0, match_flow 0, match_offset 0, drop_cnt 0, char_out 0, state_load 0.
- Reset mid-packet: FSM to IDLE immediately, context of in-flight flow not saved, pending match report dropped.
- Per packet overhead: 1 IDLE + 1 LOAD + 1 SAVE cycle; N-byte packet at full rate occupies N+3 cycles.
- sop&eop single-byte packet: IDLE, LOAD, one STREAM transfer, SAVE.
- Match report latency: 1 cycle after the accepting byte's transfer.
- Back-to-back packets of same flow: SAVE writes ctx before next LOAD reads it (LOAD is at least 2 cycles later); no bypass needed.

## Configuration
- DPI_FLOW_CTX_CLR_EN defined: adds ports ctx_clr (in, 1) and ctx_clr_flow (in, FLOW_W); ctx_clr sets ctx[ctx_clr_flow] to 0 that cycle in any FSM state. Same-cycle SAVE to the same entry: clear wins. Clear during LOAD of the same entry: state_load drives 0.
- Undefined: ports absent, entries change only by SAVE or rst.

## Test plan
- Flow 2 packet 3 bytes 0x41,0x42,0x43 after reset -> state_load_vld once with state_load 0, three char_out_vld pulses with same data, ctx[2] = matcher final state, drop_cnt 0.
- Flow 5 packet ending in matcher state 7, then flow 5 packet -> second LOAD drives state_load 7; interleaved flow 1 packet loads 0.
- Matcher accepts on byte index 4 of flow 9 packet -> match_vld one cycle later, match_flow 9, match_offset 4.
- Two non-sop beats in IDLE, then sop on flow 3 with no eop, then sop flow 4 -> drop_cnt 2; flow 3 state saved; flow 4 sop beat held until after SAVE, then LOAD.
- rst asserted in STREAM after 2 bytes of flow 6 -> outputs at reset values next cycle, ctx[6] = 0.
- With DPI_FLOW_CTX_CLR_EN: ctx_clr flow 5 in same cycle as SAVE of flow 5 -> ctx[5] = 0; next flow 5 LOAD drives 0.
